bram_level_fifo: RTL
====================

# bram_level_fifo

Parametrised successor to the standard BRAM FIFO: single-clock, block-RAM-backed FIFO with a one-cycle registered read port, generalised with a fill-level count, almost-full/almost-empty watermarks, defined handling of reads/writes at the boundaries, and optional sticky overflow/underflow error flags. Sits between a producer and a consumer in the same clock domain, where upstream flow control needs early warning rather than bare full/empty.

## Interface
- DATA_WIDTH, 8, width of src_data/dest_data
- ADDR_WIDTH, 3, depth is 2**ADDR_WIDTH entries (all usable)
- ALMOST_FULL_THRESH, 6, almost_full asserted when count >= this; legal 1..2**ADDR_WIDTH
- ALMOST_EMPTY_THRESH, 2, almost_empty asserted when count <= this; legal 0..2**ADDR_WIDTH-1

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- src_data  input  DATA_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request
- dest_data  output  DATA_WIDTH  read data, registered
- full  output  1  count == 2**ADDR_WIDTH
- empty  output  1  count == 0
- almost_full  output  1  count >= ALMOST_FULL_THRESH
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESH
- count  output  ADDR_WIDTH+1  current occupancy
- overflow  output  1  sticky: write attempted while full and not accepted
- underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: dual-port RAM of 2**ADDR_WIDTH x DATA_WIDTH; write pointer and read pointer each ADDR_WIDTH bits, wrap modulo depth naturally; occupancy held in count (ADDR_WIDTH+1 bits), not derived from pointers.
- Write accepted when wr_en && (!full || rd_accepted); data stored at write pointer, pointer increments.
- Read accepted when rd_en && !empty; RAM at read pointer latched into dest_data, pointer increments.
- Simultaneous accepted read+write: count unchanged; at full both proceed (read frees the slot being written); at empty only the write proceeds (read is underflow).
- count: +1 on write only, -1 on read only, unchanged on both/neither; never exceeds 2**ADDR_WIDTH or drops below 0.
- Rejected requests leave contents, pointers, count and dest_data untouched.
- dest_data holds its last value when no read is accepted.
- Reset: pointers 0, count 0, dest_data 0, full 0, empty 1, almost_full 0, almost_empty 1, overflow 0, underflow 0. Any wr_en/rd_en in a reset cycle is ignored; reset mid-operation discards all contents. RAM contents are not cleared.

## Timing
- All outputs registered; flags and count reflect the state after the previous edge.
- Read latency: rd_en accepted at edge N -> dest_data valid after edge N (readable in cycle N+1).
- Write-to-read: word written at edge N is readable (empty deasserts) after edge N; rd_en in cycle N+1 returns it after edge N+1.
- full/empty/almost_* /count update on the same edge as the accepted operation.
- Error flags set on the edge of the offending request; cleared only by rst.

## Configuration
- BRAM_LEVEL_FIFO_ERR_FLAGS_EN defined: overflow/underflow logic as above.
- Not defined: overflow and underflow tied to 0; rejection behaviour of boundary requests unchanged.

## Test plan
- Reset then write 0x01..0x08 (depth 8) -> count 8, full 1 after 8th edge, almost_full 1 from count 6; then read 8 -> dest_data 0x01..0x08 in order, each one cycle after rd_en, empty 1 at end.
- Fill to 8, wr_en with 0xAA alone -> rejected, count stays 8, overflow 1 (0 without macro); subsequent reads never return 0xAA.
- Full, wr_en+rd_en same cycle with 0x55 -> dest_data = oldest word, count stays 8; draining returns 0x55 last.
- Empty, wr_en 0x33 + rd_en same cycle -> count 1, dest_data unchanged, underflow 1; next rd_en -> dest_data 0x33.
- Write 12, read 12 interleaved across pointer wrap -> data order preserved, count tracks exactly, almost_empty 1 whenever count <= 2.
- Count 5, assert rst with wr_en/rd_en high -> next cycle count 0, empty 1, dest_data 0, flags cleared.

Source files
------------

// File: rtl/bram_level_fifo.sv
// Single-clock BRAM-backed FIFO with registered read port, occupancy count and watermarks.
// Define BRAM_LEVEL_FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags.
module bram_level_fifo #(
   parameter int DATA_WIDTH          = 8,
   parameter int ADDR_WIDTH          = 3,
   parameter int ALMOST_FULL_THRESH  = 6,
   parameter int ALMOST_EMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] src_data,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dest_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [ADDR_WIDTH:0]   count_next;

   // A read in the same cycle frees the slot, so a full FIFO can still accept a write.
   always_comb begin
      rd_acc = rd_en && !empty;
      wr_acc = wr_en && (!full || rd_acc);
      count_next = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Storage is deliberately left uncleared by reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[wr_ptr] <= src_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         dest_data    <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr    <= rd_ptr + 1'b1;
            dest_data <= mem[rd_ptr];
         end
         count        <= count_next;
         full         <= (count_next == DEPTH_C);
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= AF_C);
         almost_empty <= (count_next <= AE_C);
      end
   end

`ifdef BRAM_LEVEL_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && !wr_acc)
            overflow <= 1'b1;
         if (rd_en && empty)
            underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule
